// File: rtl/tdm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_pkg : shared constants, state encoding and slot decode helper     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package tdm_pkg;

  localparam int NUM_SLOTS = 16;
  localparam int SLOT_W    = 4;

  typedef logic [0:0] state_t;
  localparam state_t HUNT = 1'b0;
  localparam state_t FILL = 1'b1;

  // Two-level decode: slot[3:2] picks the group of four, slot[1:0] the bit in it.
  function automatic logic [NUM_SLOTS-1:0] slot_sel(input logic [SLOT_W-1:0] s);
    logic [3:0]           grp;
    logic [3:0]           sub;
    logic [NUM_SLOTS-1:0] sel;
    grp = 4'b0001 << s[3:2];
    sub = 4'b0001 << s[1:0];
    for (int g = 0; g < 4; g++) begin
      for (int b = 0; b < 4; b++) begin
        sel[g*4 + b] = grp[g] & sub[b];
      end
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tdm_demux16_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_demux16_if : serial TDM input beat and parallel frame output      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
interface tdm_demux16_if;
  import tdm_pkg::*;

  logic                 in_bit;
  logic                 in_valid;
  logic                 frame_start;
  logic [NUM_SLOTS-1:0] out_data;
  logic                 out_valid;
  logic [SLOT_W-1:0]    slot;
  logic                 locked;
  logic                 sync_err;

  modport master (
    output in_bit, in_valid, frame_start,
    input  out_data, out_valid, slot, locked, sync_err
  );

  modport slave (
    input  in_bit, in_valid, frame_start,
    output out_data, out_valid, slot, locked, sync_err
  );

endinterface
`default_nettype wire

// File: rtl/tdm_slot_ctr.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_slot_ctr : slot counter, priority clear > load-to-1 > increment   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              en,
  input  wire logic              load1,
  input  wire logic              clr,
  output logic [SLOT_W-1:0]      count
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load1) begin
      cnt_d = SLOT_W'(1);
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;

endmodule
`default_nettype wire

// File: rtl/tdm_demux16.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tdm_demux16 : 16-slot serial TDM frame deserialiser with framing FSM  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tdm_demux16
  import tdm_pkg::*;
(
  input  wire logic     clk,
  input  wire logic     rst_n,
  tdm_demux16_if.slave  bus
);

  state_t                state_q, state_d;
  logic [NUM_SLOTS-2:0]  shadow_q, shadow_d;
  logic [NUM_SLOTS-1:0]  out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  sync_err_q, sync_err_d;

  logic [SLOT_W-1:0]     slot;
  logic [NUM_SLOTS-1:0]  wr_sel;
  logic                  ctr_en, ctr_load1, ctr_clr;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ctr_en),
    .load1 (ctr_load1),
    .clr   (ctr_clr),
    .count (slot)
  );

  assign wr_sel = slot_sel(slot);

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    sync_err_d  = 1'b0;
    ctr_en      = 1'b0;
    ctr_load1   = 1'b0;
    ctr_clr     = 1'b0;
    if (bus.in_valid) begin
      if (bus.frame_start) begin
        // A frame start anywhere but slot 0 of a locked frame aborts the partial frame.
        if (state_q == FILL && !wr_sel[0]) begin
          sync_err_d = 1'b1;
        end
        shadow_d[0] = bus.in_bit;
        ctr_load1   = 1'b1;
        state_d     = FILL;
      end else if (state_q == FILL) begin
        if (wr_sel[0]) begin
          sync_err_d = 1'b1;
          ctr_clr    = 1'b1;
          state_d    = HUNT;
        end else if (wr_sel[NUM_SLOTS-1]) begin
          out_data_d  = {bus.in_bit, shadow_q};
          out_valid_d = 1'b1;
          ctr_en      = 1'b1;
        end else begin
          shadow_d = (shadow_q & ~wr_sel[NUM_SLOTS-2:0])
                   | ({(NUM_SLOTS-1){bus.in_bit}} & wr_sel[NUM_SLOTS-2:0]);
          ctr_en   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      shadow_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.slot      = slot;
  assign bus.locked    = (state_q == FILL);
  assign bus.sync_err  = sync_err_q;

endmodule
`default_nettype wire

// File: doc/tdm_demux16.md
TDM_DEMUX16 -- requirements
Module: tdm_demux16

Interface
REQ-001 Parameters: none; slot count fixed at 16, slot index width fixed at 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_bit  input  1  serial TDM data bit for the current slot.
REQ-005 in_valid  input  1  in_bit/frame_start qualifier; a beat is accepted only when high.
REQ-006 frame_start  input  1  marks the accepted beat as slot 0 of a frame; ignored when in_valid low.
REQ-007 out_data  output  16  last completed frame; bit k = bit received in slot k.
REQ-008 out_valid  output  1  one-cycle pulse; out_data updated this cycle.
REQ-009 slot  output  4  index the next accepted beat will be written to.
REQ-010 locked  output  1  high while in state FILL.
REQ-011 sync_err  output  1  one-cycle pulse on any framing violation.

Function
REQ-012 FSM states: HUNT, FILL; a shared 4-bit slot counter and a 15-bit shadow register hold slots 0..14.
REQ-013 HUNT: accepted beats without frame_start are discarded; slot holds 0.
REQ-014 HUNT, accepted beat with frame_start: shadow[0] <= in_bit, slot <= 1, next state FILL.
REQ-015 FILL, accepted beat, no frame_start, slot 1..14: shadow[slot] <= in_bit, slot increments.
REQ-016 FILL, accepted beat at slot 15 without frame_start: out_data <= {in_bit, shadow[14:0]}, out_valid pulses the following cycle, slot wraps to 0.
REQ-017 FILL, slot 0, accepted beat with frame_start: shadow[0] <= in_bit, slot <= 1; normal back-to-back frame, no error.
REQ-018 FILL, slot 0, accepted beat without frame_start: sync_err pulses, beat discarded, next state HUNT, slot 0.
REQ-019 FILL, slot 1..15, accepted beat with frame_start: sync_err pulses, partial frame discarded (no out_valid), beat taken as new slot 0, slot <= 1, state stays FILL.
REQ-020 in_valid low: state, slot, shadow, out_data unchanged; out_valid and sync_err low.
REQ-021 Latency: out_valid/out_data registered, exactly 1 cycle after the clock edge accepting slot 15.
REQ-022 out_data holds its value between frames; never partially updated.
REQ-023 out_valid and sync_err never asserted in the same cycle.
REQ-024 Full-throughput: in_valid continuously high with frame_start every 16th beat yields out_valid every 16 cycles with no gap.

Reset
REQ-025 rst_n low asynchronously forces: state HUNT, slot 0, shadow 0, out_data 0, out_valid 0, locked 0, sync_err 0.
REQ-026 Reset mid-frame discards the partial frame; no out_valid follows reset release.
REQ-027 After rst_n release, first accepted beat is evaluated on the first rising edge.

Structure
REQ-028 Shared package tdm_pkg holds: state enum (HUNT, FILL), NUM_SLOTS = 16, SLOT_W = 4.
REQ-029 One sub-module tdm_slot_ctr: 4-bit counter with enable, synchronous load-to-1, clear, async active-low reset.
REQ-030 Slot-to-bit steering mirrors the 16:1 selector ordering: slot k maps to bit k, slot[3:2] high group, slot[1:0] within group.

Verification
REQ-031 Reset, then 16 beats 0xA5C3 LSB first, frame_start on beat 0 -> out_valid once, out_data = 0xA5C3, locked = 1.
REQ-032 Two back-to-back frames 0x1234 then 0xFFFF, in_valid constant high -> out_valid pulses exactly 16 cycles apart with those values.
REQ-033 Frame 0x00FF with in_valid low for 3 cycles after slots 4 and 11 -> out_data = 0x00FF, slot frozen during gaps.
REQ-034 frame_start reasserted at slot 9 then full frame 0xBEEF -> sync_err pulse, no out_valid for partial frame, then out_data = 0xBEEF.
REQ-035 After good frame, slot-0 beat without frame_start -> sync_err pulse, locked = 0, beats discarded until next frame_start.
REQ-036 rst_n asserted at slot 7, released, then full frame 0x8001 -> outputs 0 during reset, single out_valid with 0x8001.
